// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and imem (slave).
// In-order responses, one per granted request; req/addr hold until gnt.
interface fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_stage.sv
// IF stage: fetch PC, up to 2 in-flight imem requests, 2-entry instr FIFO; FETCH_STATS_EN adds perf counters.
// Latency: gnt at N, rvalid at N+1 -> ValidF at N+2; StallF holds the head and requests stop once credits run out.

module fifo_sync #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       push_dat_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       head_dat_o,
   output logic [$clog2(DEPTH):0] count_o
);
   // DEPTH must be a power of two so the pointers wrap naturally.
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
   end

   assign head_dat_o = mem_q[rd_ptr_q];
   assign count_o    = count_q;
endmodule

module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h1000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0033
) (
   input  logic          clk,
   input  logic          rst,
   fetch_stage_if.master imem,
   input  logic          StallF,
   input  logic          redirect,
   input  logic [31:0]   redirect_pc,
   output logic [31:0]   InstrF,
   output logic [31:0]   PCF,
   output logic [31:0]   PC_Plus4F,
   output logic          ValidF
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]   perf_fetch_cnt,
   output logic [31:0]   perf_discard_cnt
`endif
);
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_ent_t;

   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [1:0]  discard_q, discard_d;
   logic [1:0]  outstanding;
   logic [1:0]  fifo_cnt;
   logic [31:0] pcq_head;
   fetch_ent_t  fifo_head, fifo_push_dat;
   logic        req, accept, rsp, rsp_drop, fifo_push, fifo_pop;

   // Credit covers both in-flight requests and buffered entries, so the FIFO can never overflow.
   assign req       = !rst && !redirect && (({1'b0, outstanding} + {1'b0, fifo_cnt}) < 3'd2);
   assign accept    = req && imem.imem_gnt;
   assign rsp       = imem.imem_rvalid && (outstanding != 2'd0);
   assign rsp_drop  = rsp && (redirect || (discard_q != 2'd0));
   assign fifo_push = rsp && !rsp_drop;
   assign fifo_pop  = ValidF && !StallF && !redirect;

   assign imem.imem_req  = req;
   assign imem.imem_addr = fetch_pc_q;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      discard_d  = discard_q;
      if (redirect) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         // Everything still in flight after this cycle belongs to the old path.
         discard_d  = outstanding + {1'b0, accept} - {1'b0, rsp};
      end else begin
         if (accept)   fetch_pc_d = fetch_pc_q + 32'd4;
         if (rsp_drop) discard_d  = discard_q - 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         discard_q  <= 2'd0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         discard_q  <= discard_d;
      end
   end

   // PCs of granted requests, popped by every legal response (kept or dropped).
   fifo_sync #(.WIDTH(32), .DEPTH(2)) u_pc_queue (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (1'b0),
      .push_i     (accept),
      .push_dat_i (fetch_pc_q),
      .pop_i      (rsp),
      .head_dat_o (pcq_head),
      .count_o    (outstanding)
   );

   assign fifo_push_dat = '{pc: pcq_head, instr: imem.imem_rdata};

   fifo_sync #(.WIDTH($bits(fetch_ent_t)), .DEPTH(2)) u_instr_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (redirect),
      .push_i     (fifo_push),
      .push_dat_i (fifo_push_dat),
      .pop_i      (fifo_pop),
      .head_dat_o (fifo_head),
      .count_o    (fifo_cnt)
   );

   assign ValidF    = (fifo_cnt != 2'd0);
   assign InstrF    = ValidF ? fifo_head.instr : NOP_INSTR;
   assign PCF       = ValidF ? fifo_head.pc : fetch_pc_q;
   assign PC_Plus4F = PCF + 32'd4;

`ifdef FETCH_STATS_EN
   logic [31:0] perf_fetch_q, perf_fetch_d;
   logic [31:0] perf_discard_q, perf_discard_d;

   always_comb begin
      perf_fetch_d   = perf_fetch_q + (fifo_pop ? 32'd1 : 32'd0);
      perf_discard_d = perf_discard_q + 32'(rsp_drop) + (redirect ? 32'(fifo_cnt) : 32'd0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetch_q   <= 32'd0;
         perf_discard_q <= 32'd0;
      end else begin
         perf_fetch_q   <= perf_fetch_d;
         perf_discard_q <= perf_discard_d;
      end
   end

   assign perf_fetch_cnt   = perf_fetch_q;
   assign perf_discard_cnt = perf_discard_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: in-order imem responder, one-cycle response latency when enabled.
module tb_fetch_stage;
   localparam logic [31:0] RESET_PC = 32'h1000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0033;

   logic        clk = 1'b0;
   logic        rst;
   logic        StallF, redirect;
   logic [31:0] redirect_pc;
   logic [31:0] InstrF, PCF, PC_Plus4F;
   logic        ValidF;
`ifdef FETCH_STATS_EN
   logic [31:0] perf_fetch_cnt, perf_discard_cnt;
   int          pops;
`endif

   fetch_stage_if imem ();

   int          n_checks = 0;
   int          n_errors = 0;
   bit          rsp_en;
   int          grants;
   logic [31:0] mem_q [$];

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk         (clk),
      .rst         (rst),
      .imem        (imem),
      .StallF      (StallF),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .InstrF      (InstrF),
      .PCF         (PCF),
      .PC_Plus4F   (PC_Plus4F),
      .ValidF      (ValidF)
`ifdef FETCH_STATS_EN
      ,
      .perf_fetch_cnt   (perf_fetch_cnt),
      .perf_discard_cnt (perf_discard_cnt)
`endif
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0013;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_head(input string tag, input logic [31:0] pc);
      chk({tag, "_valid"}, 32'(ValidF), 32'd1);
      chk({tag, "_pc"}, PCF, pc);
      chk({tag, "_pc4"}, PC_Plus4F, pc + 32'd4);
      chk({tag, "_instr"}, InstrF, mem_word(pc));
   endtask

   // One clock: record the handshake, cross the edge, then present the next in-order response.
   task automatic step();
      logic        hs;
      logic [31:0] hs_addr;
      #1;
      hs      = imem.imem_req && imem.imem_gnt;
      hs_addr = imem.imem_addr;
      @(posedge clk);
      if (hs) grants++;
      @(negedge clk);
      if (imem.imem_rvalid) void'(mem_q.pop_front());
      if (hs) mem_q.push_back(hs_addr);
      imem.imem_rvalid = rsp_en && (mem_q.size() > 0);
      imem.imem_rdata  = (mem_q.size() > 0) ? mem_word(mem_q[0]) : 32'h0;
   endtask

   task automatic do_reset(input bit keep_mem);
      rst              = 1'b1;
      redirect         = 1'b0;
      StallF           = 1'b0;
      rsp_en           = 1'b0;
      imem.imem_gnt    = 1'b0;
      imem.imem_rvalid = 1'b0;
      if (!keep_mem) mem_q.delete();
      step();
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; StallF = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      rsp_en = 1'b0; grants = 0;
      imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = 32'h0;
      #1;
      chk("rst_req", 32'(imem.imem_req), 32'd0);
      chk("rst_valid", 32'(ValidF), 32'd0);
      chk("rst_instr", InstrF, NOP);
      chk("rst_pc", PCF, RESET_PC);
      chk("rst_pc4", PC_Plus4F, 32'h1000_0004);
      @(negedge clk);
      rst = 1'b0;

      // Streaming fetch, memory always ready.
      imem.imem_gnt = 1'b1; rsp_en = 1'b1; #1;
      chk("t1_req0", 32'(imem.imem_req), 32'd1);
      chk("t1_addr0", imem.imem_addr, 32'h1000_0000);
      step();
      chk("t1_addr1", imem.imem_addr, 32'h1000_0004);
      chk("t1_nvalid", 32'(ValidF), 32'd0);
      step();
      expect_head("t1_head0", 32'h1000_0000);
      chk("t1_req_full", 32'(imem.imem_req), 32'd0);
      step();
      expect_head("t1_head1", 32'h1000_0004);
      chk("t1_addr2", imem.imem_addr, 32'h1000_0008);

      // Stall held 5 cycles.
      do_reset(1'b0);
      StallF = 1'b1; imem.imem_gnt = 1'b1; rsp_en = 1'b1; grants = 0;
      repeat (5) step();
      chk("t2_grants", 32'(grants), 32'd2);
      chk("t2_req", 32'(imem.imem_req), 32'd0);
      expect_head("t2_head", 32'h1000_0000);
      StallF = 1'b0;
      step();
      expect_head("t2_next", 32'h1000_0004);
      chk("t2_req_on", 32'(imem.imem_req), 32'd1);
      chk("t2_addr", imem.imem_addr, 32'h1000_0008);

      // Redirect with two requests outstanding.
      do_reset(1'b0);
      imem.imem_gnt = 1'b1;
      step(); step();
      chk("t3_req_full", 32'(imem.imem_req), 32'd0);
      rsp_en = 1'b1; redirect = 1'b1; redirect_pc = 32'h2000_0010; #1;
      chk("t3_req_redir", 32'(imem.imem_req), 32'd0);
      step();
      redirect = 1'b0; #1;
      chk("t3_req_wait", 32'(imem.imem_req), 32'd0);
      chk("t3_nvalid0", 32'(ValidF), 32'd0);
      chk("t3_empty_pc", PCF, 32'h2000_0010);
      step();
      chk("t3_nvalid1", 32'(ValidF), 32'd0);
      chk("t3_req_new", 32'(imem.imem_req), 32'd1);
      chk("t3_addr_new", imem.imem_addr, 32'h2000_0010);
      step();
      chk("t3_nvalid2", 32'(ValidF), 32'd0);
      step();
      expect_head("t3_head", 32'h2000_0010);

      // Redirect in the same cycle as gnt and rvalid.
      do_reset(1'b0);
      imem.imem_gnt = 1'b1; rsp_en = 1'b1;
      step();
      redirect = 1'b1; redirect_pc = 32'h3000_0000; #1;
      chk("t4_req_redir", 32'(imem.imem_req), 32'd0);
      step();
      redirect = 1'b0; #1;
      chk("t4_nvalid0", 32'(ValidF), 32'd0);
      chk("t4_req", 32'(imem.imem_req), 32'd1);
      chk("t4_addr", imem.imem_addr, 32'h3000_0000);
      step();
      chk("t4_nvalid1", 32'(ValidF), 32'd0);
      step();
      expect_head("t4_head", 32'h3000_0000);

      // Grant withheld, then a misaligned redirect.
      do_reset(1'b0);
      rsp_en = 1'b1;
      step();
      chk("t5_hold_req", 32'(imem.imem_req), 32'd1);
      chk("t5_hold_addr0", imem.imem_addr, 32'h1000_0000);
      step();
      chk("t5_hold_addr1", imem.imem_addr, 32'h1000_0000);
      redirect = 1'b1; redirect_pc = 32'h4000_0007; #1;
      chk("t5_req_redir", 32'(imem.imem_req), 32'd0);
      step();
      redirect = 1'b0; #1;
      chk("t5_req", 32'(imem.imem_req), 32'd1);
      chk("t5_addr_align", imem.imem_addr, 32'h4000_0004);
      imem.imem_gnt = 1'b1;
      step(); step();
      expect_head("t5_head", 32'h4000_0004);

      // Back-to-back redirects, a stale response lands in the second one.
      do_reset(1'b0);
      imem.imem_gnt = 1'b1;
      step(); step();
      rsp_en = 1'b1; redirect = 1'b1; redirect_pc = 32'h5000_0000;
      step();
      redirect_pc = 32'h6000_0000;
      step();
      redirect = 1'b0; #1;
      chk("t6_req", 32'(imem.imem_req), 32'd1);
      chk("t6_addr", imem.imem_addr, 32'h6000_0000);
      chk("t6_nvalid0", 32'(ValidF), 32'd0);
      step();
      chk("t6_nvalid1", 32'(ValidF), 32'd0);
      step();
      expect_head("t6_head", 32'h6000_0000);

      // PC wrap at the top of the address space.
      do_reset(1'b0);
      imem.imem_gnt = 1'b1; rsp_en = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect = 1'b0; #1;
      chk("t7_addr_top", imem.imem_addr, 32'hFFFF_FFFC);
      step();
      chk("t7_addr_wrap", imem.imem_addr, 32'h0000_0000);
      step();
      chk("t7_valid", 32'(ValidF), 32'd1);
      chk("t7_pc", PCF, 32'hFFFF_FFFC);
      chk("t7_pc4_wrap", PC_Plus4F, 32'h0000_0000);

      // Reset with two responses still owed by memory.
      do_reset(1'b0);
      imem.imem_gnt = 1'b1;
      step(); step();
      do_reset(1'b1);
      #1;
      chk("t8_rst_valid", 32'(ValidF), 32'd0);
      chk("t8_rst_pc", PCF, RESET_PC);
      rsp_en = 1'b1;
      step(); step(); step();
      chk("t8_stale_valid", 32'(ValidF), 32'd0);
      chk("t8_stale_pc", PCF, RESET_PC);
      chk("t8_addr", imem.imem_addr, RESET_PC);

`ifdef FETCH_STATS_EN
      do_reset(1'b0);
      imem.imem_gnt = 1'b1; rsp_en = 1'b1; pops = 0;
      chk("t9_fetch_rst", perf_fetch_cnt, 32'd0);
      chk("t9_disc_rst", perf_discard_cnt, 32'd0);
      for (int i = 0; i < 40 && pops < 4; i++) begin
         #1;
         if (ValidF && !StallF) pops++;
         step();
      end
      StallF = 1'b1;
      repeat (4) step();
      redirect = 1'b1; redirect_pc = 32'h7000_0000;
      step();
      redirect = 1'b0;
      chk("t9_fetch_cnt", perf_fetch_cnt, 32'd4);
      chk("t9_disc_cnt", perf_discard_cnt, 32'd2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage: owns the fetch PC, issues in-order requests to instruction memory and buffers returned instructions.
- Presents {InstrF, PCF, PC_Plus4F, ValidF} to the F/D pipeline register.
- Supports decode-side stall (StallF) and execute-side redirect (branch/jump), discarding in-flight stale responses.
- Up to 2 outstanding memory requests; 2-entry instruction FIFO.

Parameters:
- RESET_PC, 32'h1000_0000: fetch PC after reset.
- NOP_INSTR, 32'h0000_0033: value driven on InstrF when ValidF=0.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous reset, active-high
- imem_req  out  1  request valid
- imem_addr  out  32  request word address (byte address, [1:0]=0)
- imem_gnt  in  1  request accepted this cycle (req&gnt = handshake)
- imem_rvalid  in  1  response valid; responses return in request order, one per granted request
- imem_rdata  in  32  response instruction
- StallF  in  1  consumer not accepting this cycle
- redirect  in  1  flush and restart fetch
- redirect_pc  in  32  new fetch PC
- InstrF  out  32  head instruction or NOP_INSTR
- PCF  out  32  PC of head instruction
- PC_Plus4F  out  32  PCF + 4
- ValidF  out  1  head entry valid

Behaviour:
- Interface: one clock clk; asynchronous active-high reset rst.
- Reset (async, immediate):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; discard=0.
  - imem_req=0, ValidF=0, InstrF=NOP_INSTR, PCF=RESET_PC, PC_Plus4F=RESET_PC+4.
- Credit rule:
  - imem_req=1 when (outstanding + fifo_count) < 2 and redirect=0.
  - imem_addr=fetch_pc.
  - Request and address held stable until gnt, except when aborted by redirect.
- Grant:
  - On req&gnt: push fetch_pc into the 2-entry pc_queue; fetch_pc += 4 (mod 2^32 wrap); outstanding++.
- Response:
  - On rvalid with discard>0: drop, discard--, outstanding--, pop pc_queue.
  - Else: push {pc_queue head, imem_rdata} into FIFO, pop pc_queue, outstanding--.
  - rvalid with outstanding=0 is illegal; ignored.
- Output:
  - ValidF=1 when FIFO non-empty; InstrF/PCF = FIFO head; PC_Plus4F=PCF+4, combinational from head.
  - Empty FIFO: InstrF=NOP_INSTR, PCF=fetch_pc.
  - Pop when ValidF && !StallF.
  - Latency: grant at cycle N with rvalid at N+1 → ValidF at N+2 (registered FIFO).
- Redirect (priority over stall and all else):
  - FIFO flushed; fetch_pc=redirect_pc; imem_req=0 that cycle.
  - discard = outstanding + (gnt accepted this cycle ? 1 : 0) − (rvalid this cycle ? 1 : 0).
  - A response arriving in the redirect cycle is dropped.
  - Next cycle: request to redirect_pc if credit allows.
- Boundaries:
  - Full (fifo_count+outstanding=2) → imem_req=0.
  - Simultaneous pop and push → count unchanged.
  - Redirect while empty with outstanding=0 → discard stays 0.
  - Back-to-back redirects: last one wins; discard accumulates correctly.
  - Misaligned redirect_pc: bits [1:0] forced to 0.
  - Reset mid-transaction: all state cleared; later responses with outstanding=0 are ignored.

Optional Feature:
- Macro FETCH_STATS_EN.
- Defined:
  - perf_fetch_cnt (out, 32): increments on each FIFO pop.
  - perf_discard_cnt (out, 32): increments on each dropped response and on each flushed FIFO entry.
  - Both wrap; both reset to 0.
- Undefined: both ports and counters absent; no other behaviour changes.

Test Plan:
- Reset release, gnt always 1, rvalid one cycle after gnt → imem_addr 0x1000_0000, 0x1000_0004, …; ValidF first high 2 cycles after first gnt; PCF sequence 0x1000_0000, 0x1000_0004.
- StallF=1 held 5 cycles with memory ready → exactly 2 requests granted, imem_req=0 afterwards, head stays 0x1000_0000; release → continues at 0x1000_0008.
- Redirect to 0x2000_0010 with 2 requests outstanding → both responses dropped, next imem_addr 0x2000_0010, first ValidF PCF=0x2000_0010, PC_Plus4F=0x2000_0014.
- Redirect in same cycle as gnt and rvalid → discard computed correctly; no stale instruction ever appears with ValidF=1.
- gnt withheld 3 cycles → imem_addr stable at 0x1000_0000; redirect in cycle 2 → address switches to redirect_pc next cycle.
- fetch_pc 0xFFFF_FFFC → wraps to 0x0000_0000; with FETCH_STATS_EN, after 4 pops and 1 redirect flushing 2 entries → perf_fetch_cnt=4, perf_discard_cnt=2.
